// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller.
//   - opcode codes as seen on the request side and on alucont
//   - PSR bit positions within the 8-bit {3'b0,Z,C,F,N,L} word
//   - FSM state encoding
//   - decode() maps a request opcode to its control bundle
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1011;
    localparam logic [3:0] OP_MOV = 4'b1101;

    localparam int PSR_L = 0;
    localparam int PSR_N = 1;
    localparam int PSR_F = 2;
    localparam int PSR_C = 3;
    localparam int PSR_Z = 4;

    // Only the five flag bits survive into the architectural PSR.
    localparam logic [7:0] PSR_MASK = 8'h1F;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    typedef struct packed {
        logic       legal;    // opcode is supported
        logic       wb;       // result goes back to rf[dst]
        logic       psr_upd;  // alu_psr becomes architectural
        logic       zero_b;   // force operand b to zero
        logic [3:0] alucont;  // code presented to the ALU
    } dec_t;

    function automatic dec_t decode(input logic [3:0] op);
        dec_t d;
        d.legal   = 1'b1;
        d.wb      = 1'b1;
        d.psr_upd = 1'b0;
        d.zero_b  = 1'b0;
        d.alucont = op;
        case (op)
            OP_AND, OP_OR, OP_XOR: d.psr_upd = 1'b0;
            OP_ADD, OP_SUB:        d.psr_upd = 1'b1;
            // CMP is a SUB whose result is discarded.
            OP_CMP: begin
                d.wb      = 1'b0;
                d.psr_upd = 1'b1;
                d.alucont = OP_SUB;
            end
            // MOV is OR with b = 0, so the ALU passes a through.
            OP_MOV: begin
                d.alucont = OP_OR;
                d.zero_b  = 1'b1;
            end
            default: begin
                d.legal = 1'b0;
                d.wb    = 1'b0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// REGS x WIDTH register file for the issue controller.
// Ports:
//   clk, reset         - clock, synchronous active-high clear of all entries
//   we, waddr, wdata   - single write port
//   raddr_a / rdata_a  - combinational read port (operand a)
//   raddr_b / rdata_b  - combinational read port (operand b)
//   dbg_addr/dbg_data  - combinational debug read port
module alu_regfile #(
    parameter int WIDTH = 16,
    parameter int REGS  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [$clog2(REGS)-1:0] waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic [$clog2(REGS)-1:0] raddr_a,
    output logic [WIDTH-1:0]        rdata_a,
    input  logic [$clog2(REGS)-1:0] raddr_b,
    output logic [WIDTH-1:0]        rdata_b,
    input  logic [$clog2(REGS)-1:0] dbg_addr,
    output logic [WIDTH-1:0]        dbg_data
);

    logic [REGS-1:0][WIDTH-1:0] mem;

    // Reset has priority so an aborted writeback never lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a  = mem[raddr_a];
    assign rdata_b  = mem[raddr_b];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller driving an external 16-bit ALU.
// One instruction per 4 cycles: IDLE (accept) -> READ (register operands)
// -> EXEC (sample ALU outputs) -> WB (writeback, PSR update, done pulse).
// Ports:
//   clk, reset                         - clock, synchronous active-high reset
//   req_valid/req_ready                - request handshake (ready only in IDLE)
//   req_op, req_src, req_dst           - opcode, source (a) and dest (b, target)
//   req_imm_en, req_imm                - immediate replaces rf[src] as a
//   alu_a, alu_b, alu_alucont          - registered operands/op to the ALU
//   alu_result, alu_psr                - combinational ALU outputs
//   done, done_result, done_illegal    - completion pulse and its payload
//   psr                                - architectural PSR
//   dbg_addr, dbg_data                 - debug register-file read
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int REGS  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [3:0]              req_op,
    input  logic [$clog2(REGS)-1:0] req_src,
    input  logic [$clog2(REGS)-1:0] req_dst,
    input  logic                    req_imm_en,
    input  logic [WIDTH-1:0]        req_imm,
    output logic [WIDTH-1:0]        alu_a,
    output logic [WIDTH-1:0]        alu_b,
    output logic [3:0]              alu_alucont,
    input  logic [WIDTH-1:0]        alu_result,
    input  logic [7:0]              alu_psr,
    output logic                    done,
    output logic [WIDTH-1:0]        done_result,
    output logic                    done_illegal,
    output logic [7:0]              psr,
    input  logic [$clog2(REGS)-1:0] dbg_addr,
    output logic [WIDTH-1:0]        dbg_data
);

    localparam int AW = $clog2(REGS);

    state_t            state, state_nx;
    logic [3:0]        op_q;
    logic [AW-1:0]     src_q, dst_q;
    logic              imm_en_q;
    logic [WIDTH-1:0]  imm_q;
    logic [WIDTH-1:0]  res_q;
    logic [7:0]        psr_hold;
    logic [WIDTH-1:0]  rd_a, rd_b;
    logic              rf_we;
    dec_t              dec;

    assign dec = decode(op_q);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = S_READ;
            end
            S_READ: state_nx = S_EXEC;
            S_EXEC: state_nx = S_WB;
            S_WB: begin
                // A reset landing on the WB edge aborts the instruction,
                // so it must not be reported as complete either.
                done     = !reset;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            imm_en_q    <= 1'b0;
            imm_q       <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_alucont <= '0;
            res_q       <= '0;
            psr_hold    <= '0;
            psr         <= '0;
        end else begin
            if (state == S_IDLE && req_valid) begin
                op_q     <= req_op;
                src_q    <= req_src;
                dst_q    <= req_dst;
                imm_en_q <= req_imm_en;
                imm_q    <= req_imm;
            end
            if (state == S_READ) begin
                alu_a       <= imm_en_q ? imm_q : rd_a;
                alu_b       <= dec.zero_b ? '0 : rd_b;
                alu_alucont <= dec.alucont;
            end
            if (state == S_EXEC) begin
                res_q    <= dec.legal ? alu_result : '0;
                psr_hold <= alu_psr;
            end
            if (state == S_WB && dec.psr_upd) begin
                psr <= psr_hold & PSR_MASK;
            end
        end
    end

    assign rf_we        = (state == S_WB) && dec.wb;
    assign done_result  = done ? res_q : '0;
    assign done_illegal = done && !dec.legal;

    alu_regfile #(
        .WIDTH (WIDTH),
        .REGS  (REGS)
    ) u_rf (
        .clk      (clk),
        .reset    (reset),
        .we       (rf_we),
        .waddr    (dst_q),
        .wdata    (res_q),
        .raddr_a  (src_q),
        .rdata_a  (rd_a),
        .raddr_b  (dst_q),
        .rdata_b  (rd_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU sits on the alu_* ports,
// each issued instruction pushes its expected completion onto a queue,
// and a negedge monitor pops/compares whenever done pulses.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [3:0]  req_src;
    logic [3:0]  req_dst;
    logic        req_imm_en;
    logic [15:0] req_imm;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_alucont;
    logic [15:0] alu_result;
    logic [7:0]  alu_psr;
    logic        done;
    logic [15:0] done_result;
    logic        done_illegal;
    logic [7:0]  psr;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] res;
        logic        ill;
        logic [15:0] old;
        int          acc;
    } sb_t;
    sb_t sb[$];

    logic [15:0] model_rf [16];

    alu_issue_ctrl #(.WIDTH(16), .REGS(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_src      (req_src),
        .req_dst      (req_dst),
        .req_imm_en   (req_imm_en),
        .req_imm      (req_imm),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_alucont  (alu_alucont),
        .alu_result   (alu_result),
        .alu_psr      (alu_psr),
        .done         (done),
        .done_result  (done_result),
        .done_illegal (done_illegal),
        .psr          (psr),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model of the existing ALU; SUB/CMP compute a - b.
    logic [16:0] wide;
    logic        fc, ff, fl;
    always_comb begin
        wide       = '0;
        fc         = 1'b0;
        ff         = 1'b0;
        fl         = 1'b0;
        alu_result = 16'h0000;
        case (alu_alucont)
            4'b0001: alu_result = alu_a & alu_b;
            4'b0010: alu_result = alu_a | alu_b;
            4'b0011: alu_result = alu_a ^ alu_b;
            4'b0101: begin
                wide       = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = wide[15:0];
                fc         = wide[16];
                ff         = (alu_a[15] == alu_b[15]) && (alu_result[15] != alu_a[15]);
            end
            4'b1001: begin
                wide       = {1'b0, alu_a} - {1'b0, alu_b};
                alu_result = wide[15:0];
                fc         = wide[16];
                fl         = wide[16];
                ff         = (alu_a[15] != alu_b[15]) && (alu_result[15] != alu_a[15]);
            end
            default: alu_result = 16'hdead;
        endcase
        alu_psr = {3'b000, (alu_result == 16'h0000), fc, ff, alu_result[15], fl};
    end

    // Completion monitor.
    sb_t e;
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done at cycle %0d result %h", cyc, done_result);
            end else begin
                e = sb.pop_front();
                checks++;
                if (done_result !== e.res) begin
                    errors++;
                    $display("FAIL done_result got %h want %h", done_result, e.res);
                end
                checks++;
                if (done_illegal !== e.ill) begin
                    errors++;
                    $display("FAIL done_illegal got %b want %b", done_illegal, e.ill);
                end
                checks++;
                if (cyc - e.acc != 3) begin
                    errors++;
                    $display("FAIL done_latency got %0d want 3", cyc - e.acc);
                end
                checks++;
                if (dbg_data !== e.old) begin
                    errors++;
                    $display("FAIL dbg_before_wb got %h want %h", dbg_data, e.old);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL done_timeout pending %0d", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] src, input logic [3:0] dst,
                         input logic ie, input logic [15:0] imm, input logic [15:0] exp_res,
                         input logic exp_wb, input logic exp_ill, input logic [7:0] exp_psr);
        sb_t ent;
        int  n = 0;
        @(negedge clk);
        req_op = op; req_src = src; req_dst = dst;
        req_imm_en = ie; req_imm = imm; dbg_addr = dst;
        req_valid = 1'b1;
        while (!req_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout op %b", op);
            req_valid = 1'b0;
            return;
        end
        ent.res = exp_res; ent.ill = exp_ill; ent.old = model_rf[dst]; ent.acc = cyc;
        sb.push_back(ent);
        if (exp_wb) model_rf[dst] = exp_res;
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle();
        checks++;
        if (dbg_data !== model_rf[dst]) begin
            errors++;
            $display("FAIL rf_r%0d got %h want %h", dst, dbg_data, model_rf[dst]);
        end
        checks++;
        if (psr !== exp_psr) begin
            errors++;
            $display("FAIL psr op %b got %b want %b", op, psr, exp_psr);
        end
    endtask

    task automatic check_rf_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = i[3:0];
            #1;
            checks++;
            if (dbg_data !== 16'h0000) begin
                errors++;
                $display("FAIL %s_r%0d got %h want 0000", tag, i, dbg_data);
            end
        end
        checks++;
        if (psr !== 8'h00) begin
            errors++;
            $display("FAIL %s_psr got %h want 00", tag, psr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", req_ready);
        end
        checks++;
        if ({done, done_illegal, done_result} !== 18'h0) begin
            errors++;
            $display("FAIL reset_done got %b/%b/%h want 0", done, done_illegal, done_result);
        end
        checks++;
        if ({alu_a, alu_b, alu_alucont} !== 36'h0) begin
            errors++;
            $display("FAIL reset_alu got %h %h %h want 0", alu_a, alu_b, alu_alucont);
        end
        check_rf_zero("reset");
    endtask

    task automatic test_logic();
        issue(OP_MOV, 4'd0, 4'd1, 1'b1, 16'hffff, 16'hffff, 1'b1, 1'b0, 8'h00);
        issue(OP_MOV, 4'd0, 4'd2, 1'b1, 16'haaaa, 16'haaaa, 1'b1, 1'b0, 8'h00);
        issue(OP_AND, 4'd1, 4'd2, 1'b0, 16'h0000, 16'haaaa, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_arith();
        issue(OP_MOV, 4'd0, 4'd3, 1'b1, 16'h0001, 16'h0001, 1'b1, 1'b0, 8'h00);
        issue(OP_ADD, 4'd0, 4'd3, 1'b1, 16'hffff, 16'h0000, 1'b1, 1'b0, 8'b0001_1000);
        issue(OP_MOV, 4'd0, 4'd4, 1'b1, 16'h4000, 16'h4000, 1'b1, 1'b0, 8'b0001_1000);
        issue(OP_ADD, 4'd0, 4'd4, 1'b1, 16'h7000, 16'hb000, 1'b1, 1'b0, 8'b0000_0110);
    endtask

    task automatic test_cmp_sub();
        issue(OP_MOV, 4'd0, 4'd5, 1'b1, 16'h0006, 16'h0006, 1'b1, 1'b0, 8'b0000_0110);
        issue(OP_CMP, 4'd0, 4'd5, 1'b1, 16'h0003, 16'hfffd, 1'b0, 1'b0, 8'b0000_1011);
        // src == dst: both operands read r2, XOR clears it.
        issue(OP_XOR, 4'd2, 4'd2, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 8'b0000_1011);
        issue(OP_OR,  4'd1, 4'd3, 1'b0, 16'h0000, 16'hffff, 1'b1, 1'b0, 8'b0000_1011);
        issue(OP_SUB, 4'd1, 4'd5, 1'b0, 16'h0000, 16'hfff9, 1'b1, 1'b0, 8'b0000_0010);
    endtask

    task automatic test_illegal_stream();
        sb_t ent;
        int  acc_n = 0;
        int  first = 0;
        int  second = 0;
        @(negedge clk);
        req_op = 4'b1111; req_src = 4'd1; req_dst = 4'd5;
        req_imm_en = 1'b0; req_imm = 16'h1234; dbg_addr = 4'd5;
        req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (req_valid && req_ready) begin
                acc_n++;
                if (acc_n == 1) first = cyc;
                else            second = cyc;
                ent.res = 16'h0000; ent.ill = 1'b1; ent.old = model_rf[5]; ent.acc = cyc;
                sb.push_back(ent);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        wait_idle();
        checks++;
        if (acc_n != 2) begin
            errors++;
            $display("FAIL stream_accepts got %0d want 2", acc_n);
        end
        checks++;
        if (second - first != 4) begin
            errors++;
            $display("FAIL stream_spacing got %0d want 4", second - first);
        end
        for (int i = 1; i < 6; i++) begin
            dbg_addr = i[3:0];
            #1;
            checks++;
            if (dbg_data !== model_rf[i]) begin
                errors++;
                $display("FAIL illegal_r%0d got %h want %h", i, dbg_data, model_rf[i]);
            end
        end
        checks++;
        if (psr !== 8'b0000_0010) begin
            errors++;
            $display("FAIL illegal_psr got %b want 00000010", psr);
        end
    endtask

    task automatic test_reset_exec();
        int dn = 0;
        @(negedge clk);
        req_op = OP_ADD; req_src = 4'd0; req_dst = 4'd5;
        req_imm_en = 1'b1; req_imm = 16'h0001; dbg_addr = 4'd5;
        req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_exec_ready got %b want 1", req_ready);
        end
        @(negedge clk);             // READ
        req_valid = 1'b0;
        @(negedge clk);             // EXEC
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL rst_exec_done got %0d pulses want 0", dn);
        end
        for (int i = 0; i < 16; i++) model_rf[i] = 16'h0000;
        check_rf_zero("rst_exec");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_src = 4'h0; req_dst = 4'h0;
        req_imm_en = 1'b0; req_imm = 16'h0; dbg_addr = 4'h0;
        for (int i = 0; i < 16; i++) model_rf[i] = 16'h0000;
        test_reset();
        test_logic();
        test_arith();
        test_cmp_sub();
        test_illegal_stream();
        test_reset_exec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
